// File: rtl/audio_frame_scheduler.sv
// Two-source stereo frame scheduler: arbitrates whole L/R frames onto a single
// sample-wide encoder port and re-aligns channels with pad samples on rejection.
module audio_frame_scheduler #(
  parameter int audio_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sel_mode,
  input  logic                   mute,
  input  logic                   s0_valid,
  input  logic                   s1_valid,
  output logic                   s0_ready,
  output logic                   s1_ready,
  input  logic [audio_width-1:0] s0_left,
  input  logic [audio_width-1:0] s0_right,
  input  logic [audio_width-1:0] s1_left,
  input  logic [audio_width-1:0] s1_right,
  output logic                   o_valid,
  output logic                   o_is_left,
  output logic [audio_width-1:0] o_audio,
  input  logic                   enc_ready,
  output logic                   active_src,
  output logic                   frame_busy,
  output logic [7:0]             resync_count,
  output logic [15:0]            underrun_count
);

  typedef enum logic [3:0] {
    IDLE, SEND_L, CHK_L, PAD_R, CHK_PR, SEND_R, CHK_R, PAD_L, CHK_PL
  } state_t;

  state_t                 state;
  logic                   rr_last;
  logic                   starving;
  logic [audio_width-1:0] left_q;
  logic [audio_width-1:0] right_q;

  logic                   grant_any;
  logic                   grant_src;
  logic [audio_width-1:0] cap_left;
  logic [audio_width-1:0] cap_right;
  logic [7:0]             resync_next;

  // Round-robin only breaks ties; a lone requester always wins.
  always_comb begin
    grant_any   = s0_valid | s1_valid;
    grant_src   = (sel_mode && s0_valid && s1_valid) ? ~rr_last : ~s0_valid;
    s0_ready    = (state == IDLE) && grant_any && !grant_src;
    s1_ready    = (state == IDLE) && grant_any && grant_src;
    cap_left    = mute ? '0 : (grant_src ? s1_left  : s0_left);
    cap_right   = mute ? '0 : (grant_src ? s1_right : s0_right);
    resync_next = (resync_count == 8'hff) ? resync_count : resync_count + 8'd1;
  end

  // NOTE: every register here uses <= so all branches see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      o_valid        <= 1'b0;
      o_is_left      <= 1'b1;
      o_audio        <= '0;
      active_src     <= 1'b0;
      rr_last        <= 1'b1;
      frame_busy     <= 1'b0;
      resync_count   <= '0;
      underrun_count <= '0;
      starving       <= 1'b0;
      left_q         <= '0;
      right_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            left_q     <= cap_left;
            right_q    <= cap_right;
            active_src <= grant_src;
            rr_last    <= grant_src;
            starving   <= 1'b0;
            frame_busy <= 1'b1;
            state      <= SEND_L;
            o_valid    <= 1'b1;
            o_is_left  <= 1'b1;
            o_audio    <= cap_left;
          end else begin
            starving <= 1'b1;
            if (!starving && underrun_count != 16'hffff)
              underrun_count <= underrun_count + 16'd1;
          end
        end
        SEND_L: if (enc_ready) begin state <= CHK_L;  o_valid <= 1'b0; end
        SEND_R: if (enc_ready) begin state <= CHK_R;  o_valid <= 1'b0; end
        PAD_R:  if (enc_ready) begin state <= CHK_PR; o_valid <= 1'b0; end
        PAD_L:  if (enc_ready) begin state <= CHK_PL; o_valid <= 1'b0; end
        CHK_L: begin
          // Encoder still ready means it wanted the right channel: pad it.
          o_valid   <= 1'b1;
          o_is_left <= 1'b0;
          if (enc_ready) begin
            resync_count <= resync_next;
            state        <= PAD_R;
            o_audio      <= '0;
          end else begin
            state   <= SEND_R;
            o_audio <= right_q;
          end
        end
        CHK_R: begin
          if (enc_ready) begin
            resync_count <= resync_next;
            state        <= PAD_L;
            o_valid      <= 1'b1;
            o_is_left    <= 1'b1;
            o_audio      <= '0;
          end else begin
            state      <= IDLE;
            frame_busy <= 1'b0;
          end
        end
        CHK_PR: begin
          if (enc_ready) resync_count <= resync_next;
          state     <= SEND_L;
          o_valid   <= 1'b1;
          o_is_left <= 1'b1;
          o_audio   <= left_q;
        end
        CHK_PL: begin
          if (enc_ready) resync_count <= resync_next;
          state     <= SEND_R;
          o_valid   <= 1'b1;
          o_is_left <= 1'b0;
          o_audio   <= right_q;
        end
        default: begin
          state      <= IDLE;
          o_valid    <= 1'b0;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Randomized bench for audio_frame_scheduler against a frame/sample-level
// reference model of arbitration, channel ordering and the event counters.
module tb_audio_frame_scheduler;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sel_mode = 1'b0, mute = 1'b0;
  logic         s0_valid = 1'b0, s1_valid = 1'b0, enc_ready = 1'b0;
  logic [W-1:0] s0_left = '0, s0_right = '0, s1_left = '0, s1_right = '0;
  logic         s0_ready, s1_ready, o_valid, o_is_left, active_src, frame_busy;
  logic [W-1:0] o_audio;
  logic [7:0]   resync_count;
  logic [15:0]  underrun_count;

  audio_frame_scheduler #(.audio_width(W)) dut (
    .clk(clk), .reset(reset), .sel_mode(sel_mode), .mute(mute),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_ready(s0_ready), .s1_ready(s1_ready),
    .s0_left(s0_left), .s0_right(s0_right), .s1_left(s1_left), .s1_right(s1_right),
    .o_valid(o_valid), .o_is_left(o_is_left), .o_audio(o_audio), .enc_ready(enc_ready),
    .active_src(active_src), .frame_busy(frame_busy),
    .resync_count(resync_count), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which sample is owed to the encoder and whether the
  // encoder's verdict on the last offered sample is still outstanding.
  typedef enum {K_LEFT, K_RIGHT, K_PAD_RIGHT, K_PAD_LEFT} kind_t;
  bit           m_busy, m_verdict, m_src, m_last, m_starve;
  kind_t        m_pend;
  logic [W-1:0] m_l, m_r;
  int           m_resync, m_under;

  bit           took_last;
  int           reject_budget;
  int           enc_mode;
  logic [W:0]   taken[$];
  bit           grants[$];

  function automatic bit m_grant_src();
    if (!sel_mode) return !s0_valid;
    if (s0_valid && s1_valid) return !m_last;
    return s1_valid;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_verdict = 0; m_src = 0; m_last = 1; m_starve = 0;
    m_pend = K_LEFT; m_l = '0; m_r = '0; m_resync = 0; m_under = 0;
    took_last = 0;
  endtask

  task automatic model_update();
    bit src;
    if (!m_busy) begin
      if (s0_valid || s1_valid) begin
        src = m_grant_src();
        m_l = mute ? '0 : (src ? s1_left : s0_left);
        m_r = mute ? '0 : (src ? s1_right : s0_right);
        m_src = src; m_last = src; m_starve = 0;
        m_busy = 1; m_pend = K_LEFT; m_verdict = 0;
      end else begin
        if (!m_starve && m_under < 65535) m_under++;
        m_starve = 1;
      end
    end else if (!m_verdict) begin
      if (enc_ready) m_verdict = 1;
    end else begin
      m_verdict = 0;
      if (enc_ready) begin
        if (m_resync < 255) m_resync++;
        case (m_pend)
          K_LEFT:      m_pend = K_PAD_RIGHT;
          K_RIGHT:     m_pend = K_PAD_LEFT;
          K_PAD_RIGHT: m_pend = K_LEFT;
          default:     m_pend = K_RIGHT;
        endcase
      end else begin
        case (m_pend)
          K_LEFT:      m_pend = K_RIGHT;
          K_RIGHT:     m_busy = 0;
          K_PAD_RIGHT: m_pend = K_LEFT;
          default:     m_pend = K_RIGHT;
        endcase
      end
    end
  endtask

  // Encoder behaviours: 0 well-behaved (optional scripted rejections),
  // 1 random stalls/rejections, 2 noise, 3 stuck ready, 4 held not-ready.
  task automatic drive_enc();
    case (enc_mode)
      0: begin
        if (!took_last) enc_ready = 1'b1;
        else if (reject_budget > 0) begin enc_ready = 1'b1; reject_budget--; end
        else enc_ready = 1'b0;
      end
      1: enc_ready = took_last ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      2: enc_ready = 1'($urandom_range(0, 1));
      3: enc_ready = 1'b1;
      default: enc_ready = 1'b0;
    endcase
  endtask

  // Called at a falling edge with source inputs already driven.
  task automatic cycle();
    bit ga, gs, exp_ov;
    logic [W-1:0] exp_audio;
    drive_enc();
    #1;
    ga = s0_valid || s1_valid;
    gs = m_grant_src();
    exp_ov = m_busy && !m_verdict;
    check("s0_ready", 32'(s0_ready), 32'(!m_busy && ga && !gs));
    check("s1_ready", 32'(s1_ready), 32'(!m_busy && ga && gs));
    check("o_valid", 32'(o_valid), 32'(exp_ov));
    check("frame_busy", 32'(frame_busy), 32'(m_busy));
    check("active_src", 32'(active_src), 32'(m_src));
    check("resync_count", 32'(resync_count), 32'(m_resync));
    check("underrun_count", 32'(underrun_count), 32'(m_under));
    if (exp_ov) begin
      exp_audio = (m_pend == K_LEFT) ? m_l : (m_pend == K_RIGHT) ? m_r : '0;
      check("o_is_left", 32'(o_is_left), 32'(m_pend == K_LEFT || m_pend == K_PAD_LEFT));
      check("o_audio", 32'(o_audio), 32'(exp_audio));
    end
    if (o_valid && enc_ready) taken.push_back({o_is_left, o_audio});
    if (s0_ready || s1_ready) grants.push_back(s1_ready);
    took_last = exp_ov && enc_ready;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; mute = 1'b0;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_is_left", 32'(o_is_left), 32'd1);
    check("rst_o_audio", 32'(o_audio), 32'd0);
    check("rst_active_src", 32'(active_src), 32'd0);
    check("rst_frame_busy", 32'(frame_busy), 32'd0);
    check("rst_resync", 32'(resync_count), 32'd0);
    check("rst_underrun", 32'(underrun_count), 32'd0);
    model_reset();
    taken.delete();
    grants.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_inputs();
    s0_valid = ($urandom_range(0, 2) != 0);
    s1_valid = ($urandom_range(0, 2) != 0);
    sel_mode = 1'($urandom_range(0, 1));
    mute     = ($urandom_range(0, 3) == 0);
    s0_left  = W'($urandom); s0_right = W'($urandom);
    s1_left  = W'($urandom); s1_right = W'($urandom);
  endtask

  initial begin
    int n;
    reject_budget = 0;
    enc_mode = 4;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Fixed priority with both sources busy; encoder joins late.
    sel_mode = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1;
    s0_left = 16'h1111; s0_right = 16'h2222; s1_left = 16'h3333; s1_right = 16'h4444;
    enc_mode = 4;
    repeat (16) cycle();
    enc_mode = 0;
    repeat (30) cycle();
    check("fixed_first_left", 32'(taken.size() > 0 ? taken[0] : '1), 32'({1'b1, 16'h1111}));
    check("fixed_first_right", 32'(taken.size() > 1 ? taken[1] : '1), 32'({1'b0, 16'h2222}));
    n = 0;
    foreach (grants[i]) if (grants[i]) n++;
    check("fixed_no_s1_grant", 32'(n), 32'd0);
    check("fixed_resync", 32'(resync_count), 32'd0);

    // Round-robin alternation.
    apply_reset();
    sel_mode = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1;
    repeat (30) cycle();
    check("rr_grant0", 32'(grants.size() > 0 ? grants[0] : 1'b1), 32'd0);
    check("rr_grant1", 32'(grants.size() > 1 ? grants[1] : 1'b0), 32'd1);
    check("rr_grant2", 32'(grants.size() > 2 ? grants[2] : 1'b1), 32'd0);

    // Encoder wanting right first: one pad, then the frame re-sent in order.
    apply_reset();
    sel_mode = 1'b0; s0_valid = 1'b1; s1_valid = 1'b0;
    s0_left = 16'h0abc; s0_right = 16'h0def;
    reject_budget = 1;
    cycle();
    s0_valid = 1'b0;
    repeat (12) cycle();
    check("pad_sample", 32'(taken.size() > 1 ? taken[1] : '1), 32'({1'b0, 16'h0000}));
    check("pad_resend_left", 32'(taken.size() > 2 ? taken[2] : '1), 32'({1'b1, 16'h0abc}));
    check("pad_resend_right", 32'(taken.size() > 3 ? taken[3] : '1), 32'({1'b0, 16'h0def}));
    check("pad_resync", 32'(resync_count), 32'd1);

    // Mute latched at capture only.
    apply_reset();
    s0_valid = 1'b1; s0_left = 16'haaaa; s0_right = 16'h5555; mute = 1'b1;
    cycle();
    mute = 1'b0; sel_mode = 1'b1;
    repeat (10) cycle();
    check("mute_left", 32'(taken.size() > 0 ? taken[0] : '1), 32'({1'b1, 16'h0000}));
    check("mute_right", 32'(taken.size() > 1 ? taken[1] : '1), 32'({1'b0, 16'h0000}));
    check("unmute_left", 32'(taken.size() > 2 ? taken[2] : '1), 32'({1'b1, 16'haaaa}));

    // Two starvation episodes around one frame.
    apply_reset();
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (100) cycle();
    s0_valid = 1'b1;
    cycle();
    s0_valid = 1'b0;
    repeat (20) cycle();
    check("underrun_two", 32'(underrun_count), 32'd2);

    // Reset in SEND_R abandons the frame immediately.
    s0_valid = 1'b1; s0_left = 16'h1234; s0_right = 16'h5678;
    n = 0;
    while (!(m_busy && m_pend == K_RIGHT && !m_verdict) && n < 50) begin
      cycle();
      n++;
    end
    check("reached_send_r", 32'(n < 50), 32'd1);
    apply_reset();
    s0_valid = 1'b1;
    repeat (6) cycle();

    // Long randomized run.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) enc_mode = $urandom_range(0, 2);
      reject_budget = ($urandom_range(0, 9) == 0) ? 1 : 0;
      rand_inputs();
      cycle();
    end

    // Stuck-ready encoder saturates the resync counter.
    enc_mode = 3; reject_budget = 0;
    s0_valid = 1'b1; s1_valid = 1'b0; mute = 1'b0;
    repeat (600) cycle();
    check("resync_saturated", 32'(resync_count), 32'd255);

    // Underrun saturation from a preloaded count.
    enc_mode = 0;
    force dut.underrun_count = 16'hfffd;
    #1;
    release dut.underrun_count;
    m_under = 16'hfffd;
    for (int e = 0; e < 4; e++) begin
      s0_valid = 1'b0;
      repeat (8) cycle();
      s0_valid = 1'b1;
      repeat (6) cycle();
    end
    check("underrun_saturated", 32'(underrun_count), 32'hffff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
